// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer between the cache array and a single-port RAM; also forwards write-throughs.
// Build option: define CACHE_CRITICAL_WORD_FIRST_EN to fetch the missed word first and wrap.
module cache_refill_ctrl #(
    parameter int unsigned RAM_ADDRESS_BITS = 10,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BLOCK_BITS       = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        miss,
    input  logic [RAM_ADDRESS_BITS-1:0] miss_address,
    input  logic                        wr_valid,
    input  logic [RAM_ADDRESS_BITS-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_ready,
    output logic                        ram_req,
    output logic                        ram_we,
    output logic [RAM_ADDRESS_BITS-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    input  logic                        ram_ack,
    input  logic [DATA_WIDTH-1:0]       ram_rdata,
    output logic                        fill_en,
    output logic [RAM_ADDRESS_BITS-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0]       fill_data,
    output logic                        busy,
    output logic                        done
);

    localparam logic [BLOCK_BITS-1:0] LastCount = '1;

    typedef enum logic [1:0] {StIdle, StWr, StRd, StFinish} state_e;

    state_e                      state_q, state_d;
    logic [BLOCK_BITS-1:0]       count_q, count_d;
    logic                        wr_ready_q, wr_ready_d;
    logic                        ram_req_q, ram_req_d;
    logic                        ram_we_q, ram_we_d;
    logic [RAM_ADDRESS_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]       ram_wdata_q, ram_wdata_d;
    logic                        fill_en_q, fill_en_d;
    logic [RAM_ADDRESS_BITS-1:0] fill_addr_q, fill_addr_d;
    logic [DATA_WIDTH-1:0]       fill_data_q, fill_data_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic                        take_wr;
    logic                        take_miss;
    logic                        accept_miss;
    logic [BLOCK_BITS-1:0]       next_count;
    logic [BLOCK_BITS-1:0]       start_offset;
    logic [BLOCK_BITS-1:0]       next_offset;

    // A request is still visible in the cycle its completion pulse is out; don't re-take it.
    assign take_wr     = wr_valid && !wr_ready_q;
    assign take_miss   = miss && !done_q;
    assign accept_miss = (state_q == StIdle) && !take_wr && take_miss;
    assign next_count  = count_q + 1'b1;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic [BLOCK_BITS-1:0] first_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_q <= '0;
        end else if (accept_miss) begin
            first_q <= miss_address[BLOCK_BITS-1:0];
        end
    end

    // Offset arithmetic is BLOCK_BITS wide, so the order wraps inside the block.
    assign start_offset = miss_address[BLOCK_BITS-1:0];
    assign next_offset  = first_q + next_count;
`else
    // Ascending order always starts at offset 0; the requested word position is not used.
    assign start_offset = miss_address[BLOCK_BITS-1:0] & {BLOCK_BITS{1'b0}};
    assign next_offset  = next_count;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            wr_ready_q  <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            fill_en_q   <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ready_q  <= wr_ready_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            fill_en_q   <= fill_en_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_wr) begin
                    state_d = StWr;
                end else if (take_miss) begin
                    state_d = StRd;
                end
            end
            StWr: begin
                if (ram_ack) begin
                    state_d = StIdle;
                end
            end
            StRd: begin
                if (ram_ack && (count_q == LastCount)) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        wr_ready_d  = 1'b0;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        fill_en_d   = 1'b0;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        done_d      = 1'b0;
        busy_d      = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (take_wr) begin
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wr_address;
                    ram_wdata_d = wr_data;
                end else if (take_miss) begin
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = {miss_address[RAM_ADDRESS_BITS-1:BLOCK_BITS], start_offset};
                    count_d    = '0;
                end
            end
            StWr: begin
                if (ram_ack) begin
                    ram_req_d  = 1'b0;
                    ram_we_d   = 1'b0;
                    wr_ready_d = 1'b1;
                end
            end
            StRd: begin
                if (ram_ack) begin
                    fill_en_d   = 1'b1;
                    fill_addr_d = ram_addr_q;
                    fill_data_d = ram_rdata;
                    if (count_q == LastCount) begin
                        ram_req_d = 1'b0;
                    end else begin
                        // Next word issued immediately; tag/index bits are kept from the base.
                        count_d    = next_count;
                        ram_addr_d = {ram_addr_q[RAM_ADDRESS_BITS-1:BLOCK_BITS], next_offset};
                    end
                end
            end
            StFinish: done_d = 1'b1;
            default: ;
        endcase
    end

    assign wr_ready  = wr_ready_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign fill_en   = fill_en_q;
    assign fill_addr = fill_addr_q;
    assign fill_data = fill_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // An outstanding RAM request must not move until it is acknowledged.
    req_hold_a: assert property (@(posedge clk) disable iff (!reset_n)
        (ram_req_q && !ram_ack) |=> (ram_req_q && $stable(ram_addr_q) && $stable(ram_we_q)));

    done_idle_a: assert property (@(posedge clk) disable iff (!reset_n)
        done_q |-> !busy_q);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl with a small RAM responder.
module tb_cache_refill_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned BB = 2;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    localparam logic [AW-1:0] Seq02b[4] = '{10'h02B, 10'h028, 10'h029, 10'h02A};
    localparam logic [AW-1:0] Seq131[4] = '{10'h131, 10'h132, 10'h133, 10'h130};
    localparam logic [AW-1:0] Seq3ff[4] = '{10'h3FF, 10'h3FC, 10'h3FD, 10'h3FE};
    localparam logic [AW-1:0] Seq2c6[4] = '{10'h2C6, 10'h2C7, 10'h2C4, 10'h2C5};
`else
    localparam logic [AW-1:0] Seq02b[4] = '{10'h028, 10'h029, 10'h02A, 10'h02B};
    localparam logic [AW-1:0] Seq131[4] = '{10'h130, 10'h131, 10'h132, 10'h133};
    localparam logic [AW-1:0] Seq3ff[4] = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF};
    localparam logic [AW-1:0] Seq2c6[4] = '{10'h2C4, 10'h2C5, 10'h2C6, 10'h2C7};
`endif
    localparam logic [AW-1:0] Seq044[4] = '{10'h044, 10'h045, 10'h046, 10'h047};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          miss = 1'b0;
    logic [AW-1:0] miss_address = '0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack = 1'b0;
    logic [DW-1:0] ram_rdata;
    logic          fill_en;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic          busy;
    logic          done;

    cache_refill_ctrl #(
        .RAM_ADDRESS_BITS(AW),
        .DATA_WIDTH      (DW),
        .BLOCK_BITS      (BB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .miss        (miss),
        .miss_address(miss_address),
        .wr_valid    (wr_valid),
        .wr_address  (wr_address),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_ack     (ram_ack),
        .ram_rdata   (ram_rdata),
        .fill_en     (fill_en),
        .fill_addr   (fill_addr),
        .fill_data   (fill_data),
        .busy        (busy),
        .done        (done)
    );

    // RAM content is a fixed function of the address.
    assign ram_rdata = {16'hC0DE, 6'b0, ram_addr};

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit ack_tied = 1'b0;
    int ack_delay = 0;
    int wait_cnt = 0;

    logic [AW-1:0] req_addr_log[$];
    logic          req_we_log[$];
    logic [DW-1:0] req_wdata_log[$];
    logic [AW-1:0] fill_addr_log[$];
    logic [DW-1:0] fill_data_log[$];
    int n_done = 0;
    int n_wr_ready = 0;
    int n_unstable = 0;
    int n_ack = 0;

    logic          req_prev = 1'b0;
    logic          rst_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;

    // Monitor at +1 after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (reset_n && rst_prev && req_prev) begin
            if (ram_ack) n_ack++;
            else if (!ram_req || ram_addr !== addr_prev) n_unstable++;
        end
        if (ram_req && (!req_prev || ram_ack)) begin
            req_addr_log.push_back(ram_addr);
            req_we_log.push_back(ram_we);
            req_wdata_log.push_back(ram_wdata);
        end
        if (fill_en) begin
            fill_addr_log.push_back(fill_addr);
            fill_data_log.push_back(fill_data);
        end
        if (done) n_done++;
        if (wr_ready) n_wr_ready++;
        req_prev  = ram_req;
        addr_prev = ram_addr;
        rst_prev  = reset_n;
    end

    // RAM responder at +2: ack each request ack_delay cycles after it starts.
    initial forever begin
        @(posedge clk);
        #2;
        if (ack_tied) begin
            ram_ack = 1'b1;
        end else if (!ram_req) begin
            ram_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (ram_ack) wait_cnt = 0;
            if (wait_cnt >= ack_delay) begin
                ram_ack = 1'b1;
            end else begin
                ram_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        req_addr_log.delete();
        req_we_log.delete();
        req_wdata_log.delete();
        fill_addr_log.delete();
        fill_data_log.delete();
        n_done = 0;
        n_wr_ready = 0;
        n_unstable = 0;
        n_ack = 0;
    endtask

    task automatic wait_done(input string tag, output int at_cyc);
        int k = 0;
        while (!done && k < 200) begin
            step();
            k++;
        end
        check_eq({tag, "_done_seen"}, done, 1);
        at_cyc = cyc;
    endtask

    task automatic wait_wr_ready(input string tag);
        int k = 0;
        while (!wr_ready && k < 200) begin
            step();
            k++;
        end
        check_eq({tag, "_wr_ready_seen"}, wr_ready, 1);
    endtask

    task automatic wait_fills(input string tag, input int n);
        int k = 0;
        while (fill_addr_log.size() < n && k < 200) begin
            step();
            k++;
        end
        check_eq({tag, "_fills_reached"}, fill_addr_log.size(), n);
    endtask

    task automatic check_refill(input string tag, input logic [AW-1:0] seq[4],
                                input int first, input int n_req);
        check_eq({tag, "_nfill"}, fill_addr_log.size(), 4);
        check_eq({tag, "_nreq"}, req_addr_log.size(), n_req);
        for (int i = 0; i < 4; i++) begin
            if (i < fill_addr_log.size()) begin
                check_eq($sformatf("%s_fill_addr%0d", tag, i), fill_addr_log[i], seq[i]);
                check_eq($sformatf("%s_fill_data%0d", tag, i), fill_data_log[i],
                         {16'hC0DE, 6'b0, seq[i]});
            end
            if (first + i < req_addr_log.size()) begin
                check_eq($sformatf("%s_req_addr%0d", tag, i), req_addr_log[first + i], seq[i]);
                check_eq($sformatf("%s_req_we%0d", tag, i), req_we_log[first + i], 0);
            end
        end
    endtask

    task automatic drop_miss_and_settle();
        step();
        miss = 1'b0;
        step();
        step();
        step();
    endtask

    int start;
    int t_done;

    initial begin
        // Reset state
        step();
        step();
        check_eq("rst_ram_req", ram_req, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        check_eq("rst_fill_en", fill_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wr_ready", wr_ready, 0);
        reset_n = 1'b1;
        step();
        step();

        // Zero-wait refill of 0x2B with ram_ack tied high
        clear_logs();
        ack_tied     = 1'b1;
        miss_address = 10'h02B;
        miss         = 1'b1;
        start        = cyc;
        wait_done("t1", t_done);
        check_eq("t1_latency", t_done - start, 6);
        check_eq("t1_busy_at_done", busy, 0);
        drop_miss_and_settle();
        check_eq("t1_busy_after", busy, 0);
        check_refill("t1", Seq02b, 0, 4);
        check_eq("t1_ndone", n_done, 1);
        ack_tied = 1'b0;
        step();

        // Write-through and miss in the same idle cycle: write goes first
        clear_logs();
        ack_delay    = 0;
        wr_valid     = 1'b1;
        wr_address   = 10'h010;
        wr_data      = 32'hDEADBEEF;
        miss         = 1'b1;
        miss_address = 10'h044;
        wait_wr_ready("t3");
        wr_valid = 1'b0;
        wait_done("t3", t_done);
        drop_miss_and_settle();
        check_eq("t3_first_we", req_we_log[0], 1);
        check_eq("t3_first_addr", req_addr_log[0], 10'h010);
        check_eq("t3_first_wdata", req_wdata_log[0], 32'hDEADBEEF);
        check_eq("t3_nwr_ready", n_wr_ready, 1);
        check_refill("t3", Seq044, 1, 5);
        check_eq("t3_ndone", n_done, 1);

        // Three wait states per word; a write arriving mid-refill waits for idle
        clear_logs();
        ack_delay    = 3;
        miss_address = 10'h131;
        miss         = 1'b1;
        wait_fills("t4", 1);
        wr_valid   = 1'b1;
        wr_address = 10'h3A0;
        wr_data    = 32'h12345678;
        wait_done("t4", t_done);
        check_eq("t4_wr_blocked", n_wr_ready, 0);
        step();
        miss = 1'b0;
        wait_wr_ready("t4");
        wr_valid = 1'b0;
        step();
        step();
        check_refill("t4", Seq131, 0, 5);
        check_eq("t4_wr_we", req_we_log[4], 1);
        check_eq("t4_wr_addr", req_addr_log[4], 10'h3A0);
        check_eq("t4_wr_wdata", req_wdata_log[4], 32'h12345678);
        check_eq("t4_unstable", n_unstable, 0);
        check_eq("t4_nack", n_ack, 5);
        check_eq("t4_ndone", n_done, 1);

        // Top of the address space: offset wraps without carry
        clear_logs();
        ack_delay    = 0;
        miss_address = 10'h3FF;
        miss         = 1'b1;
        wait_done("t5", t_done);
        drop_miss_and_settle();
        check_refill("t5", Seq3ff, 0, 4);
        check_eq("t5_ndone", n_done, 1);

        // Reset after the second word, then a complete refill
        clear_logs();
        ack_delay    = 1;
        miss_address = 10'h2C6;
        miss         = 1'b1;
        wait_fills("t6", 2);
        reset_n = 1'b0;
        miss    = 1'b0;
        #1;
        check_eq("t6_rst_ram_req", ram_req, 0);
        check_eq("t6_rst_ram_addr", ram_addr, 0);
        check_eq("t6_rst_fill_en", fill_en, 0);
        check_eq("t6_rst_fill_addr", fill_addr, 0);
        check_eq("t6_rst_fill_data", fill_data, 0);
        check_eq("t6_rst_busy", busy, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        check_eq("t6_nfill_after_rst", fill_addr_log.size(), 2);
        check_eq("t6_ndone_after_rst", n_done, 0);
        clear_logs();
        miss = 1'b1;
        wait_done("t6b", t_done);
        drop_miss_and_settle();
        check_refill("t6b", Seq2c6, 0, 4);
        check_eq("t6b_ndone", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
